// File: rtl/seq_cla_subtractor_pkg.sv
// Shared definitions for the sequential carry-lookahead subtractor:
// FSM state encoding and the width of one arithmetic slice.
package seq_cla_subtractor_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_cla_subtractor_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// All carries are formed in parallel from generate/propagate terms.
module cla_slice_4bit
    import seq_cla_subtractor_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Two-level lookahead: no carry depends on a previously computed carry.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum  = w_p ^ w_c[SLICE_W-1:0];
    assign cout = w_c[SLICE_W];

endmodule

// File: rtl/seq_cla_subtractor.sv
// Sequential subtractor: A - B - Bin computed as A + ~B + ~Bin, one 4-bit
// slice per cycle through a single shared CLA slice, with valid/ready handshakes.
module seq_cla_subtractor
    import seq_cla_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int MSB   = WIDTH - 1;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_diff_final;

    assign w_a_slice = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_b_slice = ~r_b[r_idx*SLICE_W +: SLICE_W];
    assign w_last    = (r_idx == IDX_W'(N - 1));

    cla_slice_4bit u_slice (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The visible Diff is only refreshed on the final slice, so it keeps the
    // previous result while a new operation is being accumulated in r_acc.
    always_comb begin
        w_diff_final = r_acc;
        w_diff_final[r_idx*SLICE_W +: SLICE_W] = w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= ~Bin;
            r_idx   <= '0;
        end else if (w_step) begin
            r_acc[r_idx*SLICE_W +: SLICE_W] <= w_sum;
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_diff <= w_diff_final;
                r_bout <= ~w_cout;
                r_ovf  <= (r_a[MSB] != r_b[MSB]) && (w_sum[SLICE_W-1] != r_a[MSB]);
            end
        end
    end

    assign Diff = r_diff;
    assign Bout = r_bout;
    assign Ovf  = r_ovf;

endmodule
